parking_gate_ctrl: RTL and testbench

- Parametrised next-generation parking-gate controller: entry/exit sensing, N-digit keypad code on K buttons, internal second prescaler, occupancy counter with configurable capacity, wrong-code lockout.
- Replaces the fixed 4-button / 20 s / external-"full" flow controller and its timer.
- Sits between debounced single-cycle button pulses and the display and lamp drivers.

---
 rtl/parking_gate_pkg.sv | 14 +
 rtl/parking_gate_ctrl_timer.sv | 32 +++
 rtl/parking_gate_ctrl.sv | 141 ++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/parking_gate_pkg.sv
// parking_gate_pkg: state encoding and width helper shared by the parking gate controller.
package parking_gate_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_OPEN    = 3'd2,
    ST_BLOCKED = 3'd3,
    ST_LOCK    = 3'd4
  } state_e;
  function automatic int btn_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/parking_gate_ctrl_timer.sv
// gate_sec_timer: one-second prescaler plus seconds counter with clear and elapsed >= limit compare.
module gate_sec_timer #(
  parameter int TICK_DIV = 700,
  parameter int SEC_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [SEC_W-1:0] i_limit,
  output logic             o_half,
  output logic             o_done
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PRE_W-1:0] r_pre;
  logic [SEC_W-1:0] r_sec;
  logic             w_tick;
  assign w_tick = r_pre == PRE_W'(TICK_DIV - 1);
  assign o_half = w_tick | (r_pre == PRE_W'(TICK_DIV / 2 - 1));
  assign o_done = r_sec >= i_limit;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre <= '0;
      r_sec <= '0;
    end else if (i_clear) begin
      r_pre <= '0;
      r_sec <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick && r_sec != '1) r_sec <= r_sec + 1'b1;
    end
  end
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: keypad-coded parking gate with occupancy count and wrong-code lockout.
// Define PARKING_GATE_BLINK_EN to blink stop_light at 1 Hz in WAIT_CODE and LOCKOUT.
module parking_gate_ctrl
  import parking_gate_pkg::*;
#(
  parameter int NUM_BUTTONS  = 4,
  parameter int CODE_LEN     = 4,
  parameter     CODE         = 16'h0123,
  parameter int CAPACITY     = 20,
  parameter int TICK_DIV     = 700,
  parameter int OPEN_TIME    = 20,
  parameter int CODE_TIMEOUT = 10,
  parameter int MAX_TRIES    = 3,
  parameter int LOCKOUT_TIME = 30,
  localparam int OCC_W       = $clog2(CAPACITY + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_se,
  input  logic                   i_si,
  input  logic [NUM_BUTTONS-1:0] i_button,
  output logic                   o_gate_open,
  output logic                   o_stop_light,
  output logic                   o_code_error,
  output logic                   o_locked,
  output logic                   o_full,
  output logic [OCC_W-1:0]       o_occupancy,
  output logic [STATE_W-1:0]     o_state
);
  localparam int BTN_W = btn_w(NUM_BUTTONS);
  localparam int IDX_W = $clog2(CODE_LEN + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int T_MAX = (OPEN_TIME > CODE_TIMEOUT)
                       ? ((OPEN_TIME > LOCKOUT_TIME) ? OPEN_TIME : LOCKOUT_TIME)
                       : ((CODE_TIMEOUT > LOCKOUT_TIME) ? CODE_TIMEOUT : LOCKOUT_TIME);
  localparam int SEC_W = $clog2(T_MAX + 1);
  state_e           r_state, w_next;
  logic             r_se, r_si, r_ok;
  logic [IDX_W-1:0] r_idx;
  logic [TRY_W-1:0] r_tries, w_tries_inc;
  logic [OCC_W-1:0] r_occ;
  logic [BTN_W-1:0] w_btn, w_exp;
  logic [SEC_W-1:0] w_limit;
  logic w_se_fall, w_si_rise, w_full, w_cmp, w_digit, w_match, w_mism;
  logic w_inc, w_dec, w_clear, w_half, w_done;
  assign w_se_fall   = ~i_se & r_se;
  assign w_si_rise   = i_si & ~r_si;
  assign w_full      = r_occ == OCC_W'(CAPACITY);
  assign w_cmp       = r_idx == IDX_W'(CODE_LEN);
  assign w_exp       = BTN_W'(CODE >> (int'(r_idx) * BTN_W));
  assign w_tries_inc = r_tries + 1'b1;
  assign w_digit     = (r_state == ST_WAIT) && r_se && !w_cmp && (|i_button);
  assign w_inc       = (r_state == ST_OPEN) && w_se_fall;
  assign w_dec       = w_si_rise;
  assign w_clear     = (w_next != r_state) || w_digit;
  always_comb begin
    w_btn = '0;
    for (int b = 0; b < NUM_BUTTONS; b++) if (i_button[b]) w_btn = BTN_W'(b);
  end
  always_comb begin
    w_next  = r_state;
    w_limit = '0;
    w_match = 1'b0;
    w_mism  = 1'b0;
    case (r_state)
      ST_IDLE: if (r_se) w_next = w_full ? ST_BLOCKED : ST_WAIT;
      ST_WAIT: begin
        w_limit = SEC_W'(CODE_TIMEOUT);
        if (!r_se) w_next = ST_IDLE;
        else if (w_cmp) begin
          w_match = r_ok;
          w_mism  = !r_ok;
          w_next  = r_ok ? ST_OPEN : (w_tries_inc >= TRY_W'(MAX_TRIES)) ? ST_LOCK : ST_WAIT;
        end else if (w_done) w_next = ST_IDLE;
      end
      ST_OPEN: begin
        w_limit = SEC_W'(OPEN_TIME);
        if (w_se_fall || w_done) w_next = ST_IDLE;
      end
      ST_BLOCKED: if (!r_se || !w_full) w_next = ST_IDLE;
      ST_LOCK: begin
        w_limit = SEC_W'(LOCKOUT_TIME);
        if (w_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end
  gate_sec_timer #(.TICK_DIV(TICK_DIV), .SEC_W(SEC_W)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_clear),
    .i_limit (w_limit),
    .o_half  (w_half),
    .o_done  (w_done)
  );
`ifdef PARKING_GATE_BLINK_EN
  logic r_blink;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_blink <= 1'b0;
    else r_blink <= ((r_state == ST_WAIT || r_state == ST_LOCK) && w_next == r_state) ? r_blink ^ w_half : 1'b0;
  end
  assign o_stop_light = (r_state != ST_OPEN) & ~r_blink;
`else
  logic w_unused_half;
  assign w_unused_half = w_half;
  assign o_stop_light  = r_state != ST_OPEN;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_se    <= 1'b0;
      r_si    <= 1'b0;
      r_idx   <= '0;
      r_ok    <= 1'b1;
      r_tries <= '0;
      r_occ   <= '0;
    end else begin
      r_state <= w_next;
      r_se    <= i_se;
      r_si    <= i_si;
      if (r_state != ST_WAIT || w_mism) begin
        r_idx <= '0;
        r_ok  <= 1'b1;
      end else if (w_digit) begin
        r_idx <= r_idx + 1'b1;
        r_ok  <= r_ok & $onehot(i_button) & (w_btn == w_exp);
      end
      if (w_match || (r_state == ST_LOCK && w_next == ST_IDLE)) r_tries <= '0;
      else if (w_mism) r_tries <= w_tries_inc;
      // simultaneous entry and exit cancel out
      r_occ <= (w_inc && !w_dec && !w_full) ? r_occ + 1'b1
             : (w_dec && !w_inc && r_occ != '0) ? r_occ - 1'b1 : r_occ;
    end
  end
  assign o_gate_open  = r_state == ST_OPEN;
  assign o_locked     = r_state == ST_LOCK;
  assign o_code_error = w_mism;
  assign o_full       = w_full;
  assign o_occupancy  = r_occ;
  assign o_state      = r_state;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed checks of code entry, lockout, capacity, timeouts and async reset.
module tb_parking_gate_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, se = 1'b0, si = 1'b0;
  logic [15:0] button = '0;
  logic        gate_open, stop_light, code_error, locked, full;
  logic [1:0]  occupancy;
  logic [2:0]  state;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  // 16 buttons give 4-bit digits, so 16'h0123 is the sequence 3,2,1,0
  parking_gate_ctrl #(
    .NUM_BUTTONS(16), .CODE_LEN(4), .CODE(16'h0123), .CAPACITY(2), .TICK_DIV(4),
    .OPEN_TIME(20), .CODE_TIMEOUT(10), .MAX_TRIES(3), .LOCKOUT_TIME(30)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_se(se), .i_si(si), .i_button(button),
    .o_gate_open(gate_open), .o_stop_light(stop_light), .o_code_error(code_error),
    .o_locked(locked), .o_full(full), .o_occupancy(occupancy), .o_state(state)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int d);
    button = '0;
    button[d] = 1'b1;
    @(negedge clk);
    button = '0;
  endtask
  task automatic enter(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask
  initial begin
    cyc(1);
    chk("rst_state", 32'(state), 0);
    chk("rst_stop", 32'(stop_light), 1);
    chk("rst_gate", 32'(gate_open), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_err", 32'(code_error), 0);
    rst_n = 1'b1;
    cyc(1);
    se = 1'b1;
    cyc(1);
    chk("se_lat1", 32'(state), 0);
    cyc(1);
    chk("se_lat2", 32'(state), 1);
    enter(3, 2, 1, 0);
    chk("gate_lat1", 32'(gate_open), 0);
    cyc(1);
    chk("gate_lat2", 32'(gate_open), 1);
    chk("open_stop", 32'(stop_light), 0);
    se = 1'b0;
    cyc(1);
    chk("pass_occ", 32'(occupancy), 1);
    chk("pass_idle", 32'(state), 0);
    se = 1'b1;
    cyc(2);
    enter(3, 2, 1, 0);
    cyc(1);
    chk("open2", 32'(state), 2);
    cyc(80);
    chk("open_hold", 32'(state), 2);
    cyc(1);
    chk("open_tmo", 32'(state), 0);
    chk("open_tmo_occ", 32'(occupancy), 1);
    cyc(1);
    chk("rewait", 32'(state), 1);
    press(3);
    press(2);
    cyc(40);
    chk("code_hold", 32'(state), 1);
    cyc(1);
    chk("code_tmo", 32'(state), 0);
    se = 1'b0;
    cyc(1);
    chk("abort_wait", 32'(state), 1);
    cyc(1);
    chk("abort_idle", 32'(state), 0);
    se = 1'b1;
    cyc(2);
    chk("wrong_wait", 32'(state), 1);
    for (int i = 0; i < 3; i++) begin
      enter(0, 0, 0, 0);
      chk("wrong_err", 32'(code_error), 1);
      chk("wrong_unlocked", 32'(locked), 0);
      cyc(1);
      chk("wrong_err_end", 32'(code_error), 0);
      chk("wrong_state", 32'(state), (i < 2) ? 1 : 4);
      chk("wrong_locked", 32'(locked), (i < 2) ? 0 : 1);
    end
    enter(3, 2, 1, 0);
    chk("lock_ignore", 32'(state), 4);
    chk("lock_gate", 32'(gate_open), 0);
    cyc(116);
    chk("lock_hold", 32'(locked), 1);
    cyc(1);
    chk("lock_end", 32'(locked), 0);
    chk("lock_idle", 32'(state), 0);
    cyc(1);
    enter(0, 0, 0, 0);
    chk("tries_err", 32'(code_error), 1);
    cyc(1);
    chk("tries_clr", 32'(state), 1);
    enter(3, 2, 1, 0);
    cyc(1);
    chk("open3", 32'(gate_open), 1);
    se = 1'b0;
    si = 1'b1;
    cyc(1);
    chk("simul_occ", 32'(occupancy), 1);
    chk("simul_idle", 32'(state), 0);
    si = 1'b0;
    se = 1'b1;
    cyc(2);
    enter(3, 2, 1, 0);
    cyc(1);
    chk("open4", 32'(gate_open), 1);
    se = 1'b0;
    cyc(1);
    chk("cap_occ", 32'(occupancy), 2);
    chk("cap_full", 32'(full), 1);
    se = 1'b1;
    cyc(2);
    chk("blocked", 32'(state), 3);
    chk("blocked_stop", 32'(stop_light), 1);
    si = 1'b1;
    cyc(1);
    chk("exit_occ", 32'(occupancy), 1);
    chk("exit_full", 32'(full), 0);
    chk("exit_blk", 32'(state), 3);
    si = 1'b0;
    cyc(1);
    chk("unblk_idle", 32'(state), 0);
    cyc(1);
    chk("unblk_wait", 32'(state), 1);
    press(3);
    press(2);
    press(1);
    button = 16'h0003;
    cyc(1);
    button = '0;
    chk("multi_err", 32'(code_error), 1);
    cyc(1);
    chk("multi_wait", 32'(state), 1);
    enter(3, 2, 1, 0);
    cyc(1);
    chk("open5", 32'(gate_open), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_gate", 32'(gate_open), 0);
    chk("arst_occ", 32'(occupancy), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_stop", 32'(stop_light), 1);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
